// File: rtl/temp_pkg.sv
// Shared definitions for the temperature stabiliser: BCD field positions,
// ASCII constants and the validity / signed-ordering helpers.
package temp_pkg;

  localparam int SIGN_HI   = 15;
  localparam int SIGN_LO   = 12;
  localparam int TENS_HI   = 11;
  localparam int TENS_LO   = 8;
  localparam int UNITS_HI  = 7;
  localparam int UNITS_LO  = 4;
  localparam int TENTHS_HI = 3;
  localparam int TENTHS_LO = 0;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_DOT   = 8'h2E;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_C     = 8'h43;

  function automatic logic bcd_valid(input logic [15:0] w);
    return (w[SIGN_HI:SIGN_LO]     <= 4'd1) &&
           (w[TENS_HI:TENS_LO]     <= 4'd9) &&
           (w[UNITS_HI:UNITS_LO]   <= 4'd9) &&
           (w[TENTHS_HI:TENTHS_LO] <= 4'd9);
  endfunction

  // Valid BCD digits order the same as plain binary, so the 12-bit magnitude
  // compares directly; a negative zero is folded onto positive zero.
  function automatic logic bcd_less(input logic [15:0] a, input logic [15:0] b);
    logic [11:0] ma;
    logic [11:0] mb;
    logic        an;
    logic        bn;
    ma = a[TENS_HI:TENTHS_LO];
    mb = b[TENS_HI:TENTHS_LO];
    an = a[SIGN_LO] && (ma != 12'd0);
    bn = b[SIGN_LO] && (mb != 12'd0);
    if (an && !bn)       return 1'b1;
    else if (!an && bn)  return 1'b0;
    else if (!an)        return ma < mb;
    else                 return ma > mb;
  endfunction

endpackage

// File: rtl/temp_char_fmt.sv
// Combinational BCD word to ASCII character for one position of the
// 6-character string "sTU.tC"; shows " --.-C" when the word is not valid.
module temp_char_fmt
  import temp_pkg::*;
(
  input  logic [15:0] i_word,
  input  logic        i_valid,
  input  logic [2:0]  i_addr,
  output logic [7:0]  o_char
);

  logic [3:0] w_tens;
  logic [3:0] w_units;
  logic [3:0] w_tenths;

  assign w_tens   = i_word[TENS_HI:TENS_LO];
  assign w_units  = i_word[UNITS_HI:UNITS_LO];
  assign w_tenths = i_word[TENTHS_HI:TENTHS_LO];

  always_comb begin
    o_char = ASC_SPACE;
    case (i_addr)
      3'd0: o_char = (i_valid && i_word[SIGN_LO]) ? ASC_MINUS : ASC_SPACE;
      3'd1: begin
        if (!i_valid)            o_char = ASC_MINUS;
        else if (w_tens == 4'd0) o_char = ASC_SPACE;
        else                     o_char = ASC_ZERO + {4'd0, w_tens};
      end
      3'd2: o_char = i_valid ? (ASC_ZERO + {4'd0, w_units}) : ASC_MINUS;
      3'd3: o_char = ASC_DOT;
      3'd4: o_char = i_valid ? (ASC_ZERO + {4'd0, w_tenths}) : ASC_MINUS;
      3'd5: o_char = ASC_C;
      default: o_char = ASC_SPACE;
    endcase
  end

endmodule

// File: rtl/temp_stable_fmt.sv
// Debounces the DS18B20 BCD temperature word by periodic sampling, tracks
// min/max of accepted values and serves an ASCII read port for the LCD.
module temp_stable_fmt
  import temp_pkg::*;
#(
  parameter int CLK_HZ    = 27_000_000,
  parameter int SAMPLE_MS = 10,
  parameter int STABLE_N  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] temperature,
  input  logic        clr_minmax,
  input  logic [1:0]  char_sel,
  input  logic [2:0]  char_addr,
  output logic [7:0]  char_data,
  output logic        temp_valid,
  output logic [15:0] temp_bcd,
  output logic [15:0] min_bcd,
  output logic [15:0] max_bcd,
  output logic        updated
);

  localparam int PRESC_TERM = CLK_HZ / 1000 * SAMPLE_MS - 1;
  localparam int PW         = (PRESC_TERM > 0) ? $clog2(PRESC_TERM + 1) : 1;
  localparam logic [PW-1:0] PRESC_END = PW'(PRESC_TERM);
  localparam logic [3:0]    N4        = 4'(STABLE_N);

  logic [PW-1:0] r_presc;
  logic [15:0]   r_prev;
  logic [3:0]    r_cnt;
  logic          r_mm_valid;

  logic          w_tick;
  logic          w_samp_ok;
  logic [3:0]    w_cnt_next;
  logic          w_accept;
  logic [15:0]   w_fmt_word;
  logic          w_fmt_valid;
  logic [7:0]    w_fmt_char;

  assign w_tick    = (r_presc == PRESC_END);
  assign w_samp_ok = bcd_valid(temperature);

  always_comb begin
    w_cnt_next = r_cnt;
    if (!w_samp_ok)                 w_cnt_next = 4'd0;
    else if (temperature != r_prev) w_cnt_next = 4'd1;
    else if (r_cnt != N4)           w_cnt_next = r_cnt + 4'd1;
  end

  // Only the transition into saturation accepts; held repeats do not.
  assign w_accept = w_tick && (w_cnt_next == N4) && (r_cnt != N4);

  always_comb begin
    w_fmt_word  = temp_bcd;
    w_fmt_valid = temp_valid;
    case (char_sel)
      2'd1: begin w_fmt_word = min_bcd; w_fmt_valid = r_mm_valid; end
      2'd2: begin w_fmt_word = max_bcd; w_fmt_valid = r_mm_valid; end
      default: begin w_fmt_word = temp_bcd; w_fmt_valid = temp_valid; end
    endcase
  end

  temp_char_fmt u_fmt (
    .i_word  (w_fmt_word),
    .i_valid (w_fmt_valid),
    .i_addr  (char_addr),
    .o_char  (w_fmt_char)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc    <= '0;
      r_prev     <= 16'd0;
      r_cnt      <= 4'd0;
      r_mm_valid <= 1'b0;
      temp_valid <= 1'b0;
      temp_bcd   <= 16'd0;
      min_bcd    <= 16'd0;
      max_bcd    <= 16'd0;
      updated    <= 1'b0;
      char_data  <= ASC_SPACE;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      updated <= 1'b0;
      if (w_tick) begin
        r_prev <= temperature;
        r_cnt  <= w_cnt_next;
      end
      if (w_accept) begin
        temp_bcd   <= temperature;
        temp_valid <= 1'b1;
        updated    <= !temp_valid || (temperature != temp_bcd);
      end
      // An accept in the same cycle as a clear restarts tracking at the new value.
      if (w_accept) begin
        if (!r_mm_valid || clr_minmax) begin
          min_bcd    <= temperature;
          max_bcd    <= temperature;
          r_mm_valid <= 1'b1;
        end else begin
          if (bcd_less(temperature, min_bcd)) min_bcd <= temperature;
          if (bcd_less(max_bcd, temperature)) max_bcd <= temperature;
        end
      end else if (clr_minmax) begin
        r_mm_valid <= 1'b0;
        min_bcd    <= 16'd0;
        max_bcd    <= 16'd0;
      end
      char_data <= (char_sel == 2'd3) ? ASC_SPACE : w_fmt_char;
    end
  end

endmodule

// File: tb/tb_temp_stable_fmt.sv
// Directed bench for temp_stable_fmt with a scoreboard of expected accepts,
// popped whenever the DUT pulses updated.
module tb_temp_stable_fmt;

  localparam int PERIOD_CYC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] temperature = 16'd0;
  logic        clr_minmax = 1'b0;
  logic [1:0]  char_sel = 2'd0;
  logic [2:0]  char_addr = 3'd0;
  logic [7:0]  char_data;
  logic        temp_valid;
  logic [15:0] temp_bcd;
  logic [15:0] min_bcd;
  logic [15:0] max_bcd;
  logic        updated;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] sb[$];

  temp_stable_fmt #(.CLK_HZ(1000), .SAMPLE_MS(10), .STABLE_N(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .temperature (temperature),
    .clr_minmax  (clr_minmax),
    .char_sel    (char_sel),
    .char_addr   (char_addr),
    .char_data   (char_data),
    .temp_valid  (temp_valid),
    .temp_bcd    (temp_bcd),
    .min_bcd     (min_bcd),
    .max_bcd     (max_bcd),
    .updated     (updated)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; sample ticks land on multiples of PERIOD_CYC.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
    $display("check %s observed=%h expected=%h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && updated) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_updated observed temp_bcd=%h expected no pulse", temp_bcd);
      end else begin
        chk("updated_value", temp_bcd, sb.pop_front());
      end
    end
  end

  // One sample tick with v on the input; returns just after the tick edge.
  task automatic step(input logic [15:0] v);
    temperature = v;
    do begin @(posedge clk); #1; end while (cyc % PERIOD_CYC != 0);
  endtask

  task automatic step_clr(input logic [15:0] v);
    temperature = v;
    do begin @(posedge clk); #1; end while (cyc % PERIOD_CYC != PERIOD_CYC - 1);
    clr_minmax = 1'b1;
    @(posedge clk); #1;
    clr_minmax = 1'b0;
  endtask

  task automatic read_str(input logic [1:0] sel, input logic [47:0] exp, input string tag);
    logic [7:0] e;
    for (int i = 0; i < 6; i++) begin
      char_sel  = sel;
      char_addr = 3'(i);
      @(posedge clk); #1;
      e = exp[47 - 8*i -: 8];
      chk($sformatf("%s_ch%0d", tag, i), {8'd0, char_data}, {8'd0, e});
    end
    char_sel  = 2'd0;
    char_addr = 3'd0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, {15'd0, temp_valid}, 16'd0);
    chk({tag, "_temp"}, temp_bcd, 16'd0);
    chk({tag, "_min"}, min_bcd, 16'd0);
    chk({tag, "_max"}, max_bcd, 16'd0);
    chk({tag, "_upd"}, {15'd0, updated}, 16'd0);
    chk({tag, "_char"}, {8'd0, char_data}, 16'h0020);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    // Alternating values never settle.
    for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 16'h0235 : 16'h0236);
    chk("alt_valid", {15'd0, temp_valid}, 16'd0);
    read_str(2'd0, " --.-C", "alt_cur");

    // Steady +23.5: accept on the fourth tick.
    for (int i = 0; i < 3; i++) step(16'h0235);
    chk("hold3_valid", {15'd0, temp_valid}, 16'd0);
    sb.push_back(16'h0235);
    step(16'h0235);
    chk("acc_valid", {15'd0, temp_valid}, 16'd1);
    chk("acc_temp", temp_bcd, 16'h0235);
    step(16'h0235);
    step(16'h0235);
    read_str(2'd0, " 23.5C", "cur235");
    chk("min235", min_bcd, 16'h0235);
    chk("max235", max_bcd, 16'h0235);

    // An invalid sample restarts the count.
    step(16'h0240);
    step(16'h0240);
    step(16'h02A5);
    for (int i = 0; i < 3; i++) step(16'h0240);
    chk("inv_hold_temp", temp_bcd, 16'h0235);
    sb.push_back(16'h0240);
    step(16'h0240);
    chk("inv_acc_temp", temp_bcd, 16'h0240);

    // Signed min/max tracking.
    sb.push_back(16'h1050);
    for (int i = 0; i < 4; i++) step(16'h1050);
    sb.push_back(16'h0301);
    for (int i = 0; i < 4; i++) step(16'h0301);
    chk("mm_min", min_bcd, 16'h1050);
    chk("mm_max", max_bcd, 16'h0301);
    read_str(2'd1, "- 5.0C", "min_str");
    read_str(2'd2, " 30.1C", "max_str");
    read_str(2'd3, "      ", "blank_sel");
    char_addr = 3'd6;
    @(posedge clk); #1;
    chk("blank_addr6", {8'd0, char_data}, 16'h0020);
    char_addr = 3'd0;

    // -00.0 sits between -05.0 and +30.1, so neither bound moves.
    sb.push_back(16'h1000);
    for (int i = 0; i < 4; i++) step(16'h1000);
    chk("negzero_min", min_bcd, 16'h1050);
    chk("negzero_max", max_bcd, 16'h0301);

    // Clear coinciding with an accept restarts at the new value.
    for (int i = 0; i < 3; i++) step(16'h0180);
    sb.push_back(16'h0180);
    step_clr(16'h0180);
    chk("clracc_min", min_bcd, 16'h0180);
    chk("clracc_max", max_bcd, 16'h0180);
    @(posedge clk); #1;
    clr_minmax = 1'b1;
    @(posedge clk); #1;
    clr_minmax = 1'b0;
    chk("clr_min", min_bcd, 16'h0000);
    chk("clr_max", max_bcd, 16'h0000);
    chk("clr_keep_temp", temp_bcd, 16'h0180);
    read_str(2'd1, " --.-C", "clr_minstr");

    // Reset mid-stability discards the partial count.
    for (int i = 0; i < 3; i++) step(16'h0235);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("midrst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(16'h0235);
    chk("rst_hold3_valid", {15'd0, temp_valid}, 16'd0);
    sb.push_back(16'h0235);
    step(16'h0235);
    chk("rst_acc_valid", {15'd0, temp_valid}, 16'd1);
    chk("rst_acc_temp", temp_bcd, 16'h0235);
    chk("rst_acc_min", min_bcd, 16'h0235);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 16'(sb.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
